// File: rtl/game_pkg.sv
// Shared types and constants for the penalty-game controller.
package game_pkg;

  typedef enum logic [2:0] {
    START   = 3'd0,
    KEEPER  = 3'd1,
    SHOOTER = 3'd2,
    WINNER  = 3'd3,
    LOOSER  = 3'd4
  } g_state;

  typedef enum logic {
    SOLO  = 1'b0,
    MULTI = 1'b1
  } g_mode;

  localparam int unsigned SCORE_W             = 4;
  localparam int unsigned ROUND_W             = 4;
  localparam int unsigned HOLD_CYCLES_DEFAULT = 130_000_000;

  // Decide the game once one side can no longer be caught with the shots left.
  function automatic g_state early_verdict(input int unsigned player, input int unsigned opponent,
                                           input int unsigned player_left,
                                           input int unsigned opponent_left,
                                           input g_state fallback);
    if (player > opponent + opponent_left) return WINNER;
    if (opponent > player + player_left) return LOOSER;
    return fallback;
  endfunction

endpackage

// File: rtl/result_hold_timer.sv
// Result display timer: load starts a hold of HOLD_CYCLES cycles, expire marks its last cycle.
module result_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic active,
  output logic expire
);

  localparam int unsigned TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [TW-1:0] count_q;
  logic          active_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      count_q  <= TW'(HOLD_CYCLES - 1);
      active_q <= 1'b1;
    end else if (active_q) begin
      if (count_q == '0) begin
        active_q <= 1'b0;
      end else begin
        count_q <= count_q - TW'(1);
      end
    end
  end

  assign active = active_q;
  assign expire = active_q && (count_q == '0);

endmodule

// File: rtl/game_controller.sv
// Penalty-game master FSM: turn sequencing, scoring, rounds and sudden death.
// Optional GAME_EARLY_FINISH_EN ends regulation as soon as the result is decided.
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned ROUNDS      = 5,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode_sel,
  input  logic                 shot_done,
  input  logic                 shot_goal,
  output g_state               game_state,
  output g_mode                game_mode,
  output logic [2*SCORE_W-1:0] score,
  output logic [ROUND_W-1:0]   round_counter,
  output logic                 is_scored,
  output logic                 hold_active
);

  g_state             state_q, state_d;
  g_mode              mode_q, mode_d;
  logic [SCORE_W-1:0] player_q, player_d, opp_q, opp_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               scored_q, scored_d;
  logic               load, hold, expire, shot_ok;

  result_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .active(hold),
    .expire(expire)
  );

  assign shot_ok = shot_done && !hold && ((state_q == SHOOTER) || (state_q == KEEPER));

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    player_d = player_q;
    opp_d    = opp_q;
    round_d  = round_q;
    scored_d = scored_q;
    load     = 1'b0;
    case (state_q)
      START: begin
        if (start) begin
          state_d  = SHOOTER;
          mode_d   = g_mode'(mode_sel);
          player_d = '0;
          opp_d    = '0;
          round_d  = '0;
          scored_d = 1'b0;
        end
      end
      SHOOTER: begin
        if (shot_ok) begin
          scored_d = shot_goal;
          load     = 1'b1;
          if (shot_goal && (player_q != '1)) player_d = player_q + SCORE_W'(1);
        end else if (expire) begin
          state_d = KEEPER;
`ifdef GAME_EARLY_FINISH_EN
          if (32'(round_q) < ROUNDS) begin
            state_d = early_verdict(32'(player_q), 32'(opp_q), ROUNDS - 32'(round_q) - 1,
                                    ROUNDS - 32'(round_q), KEEPER);
          end
`endif
        end
      end
      KEEPER: begin
        if (shot_ok) begin
          scored_d = shot_goal;
          load     = 1'b1;
          if (shot_goal && (opp_q != '1)) opp_d = opp_q + SCORE_W'(1);
          if (round_q != '1) round_d = round_q + ROUND_W'(1);
        end else if (expire) begin
          // round_q already counts the pair just completed
          if ((32'(round_q) >= ROUNDS) && (player_q != opp_q)) begin
            state_d = (player_q > opp_q) ? WINNER : LOOSER;
          end else begin
            state_d = SHOOTER;
          end
`ifdef GAME_EARLY_FINISH_EN
          if (32'(round_q) <= ROUNDS) begin
            state_d = early_verdict(32'(player_q), 32'(opp_q), ROUNDS - 32'(round_q),
                                    ROUNDS - 32'(round_q), state_d);
          end
`endif
        end
      end
      WINNER, LOOSER: begin
        if (start) state_d = START;
      end
      default: state_d = START;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= START;
      mode_q   <= MULTI;
      player_q <= '0;
      opp_q    <= '0;
      round_q  <= '0;
      scored_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      player_q <= player_d;
      opp_q    <= opp_d;
      round_q  <= round_d;
      scored_q <= scored_d;
    end
  end

  assign game_state    = state_q;
  assign game_mode     = mode_q;
  assign score         = {player_q, opp_q};
  assign round_counter = round_q;
  assign is_scored     = scored_q;
  assign hold_active   = hold;

endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
- Penalty-game master FSM. Sits directly upstream of the screen selector and produces every field it consumes: game_state, game_mode, score, round_counter, is_scored.
- Sequences START -> alternating SHOOTER/KEEPER turns -> WINNER/LOOSER.
- Counts goals and rounds, including sudden death.
- Holds each shot result on screen for a fixed time before changing turn.

Parameters:
- ROUNDS, 5, regulation shot pairs.
- HOLD_CYCLES, 130_000_000, result display time in clk cycles (2 s at 65 MHz); must be >= 1.

Ports:
- clk  in  1  pixel/system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse (debounced click): begin game / return to START
- mode_sel  in  1  0=SOLO, 1=MULTI; sampled on the START->SHOOTER transition
- shot_done  in  1  single-cycle pulse: current shot resolved
- shot_goal  in  1  valid with shot_done: 1=goal scored by the current shooter
- game_state  out  g_state (game_pkg enum)  START/KEEPER/SHOOTER/WINNER/LOOSER
- game_mode  out  g_mode  latched mode
- score  out  8  {player[7:4], opponent[3:0]}
- round_counter  out  4  completed shot pairs
- is_scored  out  1  result of last shot; valid while hold is active
- hold_active  out  1  result display in progress

Behaviour:
- Reset values (async on rst=0): game_state=START, game_mode=MULTI, score=0, round_counter=0, is_scored=0, hold_active=0, hold timer=0. All outputs registered.
- START:
  - start=1 -> SHOOTER next cycle.
  - Same edge: score, round_counter and is_scored cleared; game_mode<=mode_sel.
  - shot_done ignored.
- SHOOTER (player shoots), with shot_done=1 and hold_active=0:
  - is_scored<=shot_goal.
  - If shot_goal=1, player+1 (saturate at 15).
  - hold_active<=1; timer loads HOLD_CYCLES-1.
- KEEPER (opponent shoots):
  - Same handling as SHOOTER, but a goal increments the opponent score.
  - round_counter+1 (saturate at 15) on the same edge.
- While hold_active=1:
  - Timer decrements each cycle; shot_done and start are ignored.
  - On the cycle the timer=0: hold_active<=0 and the turn resolves.
- Turn resolution:
  - From SHOOTER -> KEEPER.
  - From KEEPER: if round_counter>=ROUNDS and scores differ -> WINNER (player>opponent) or LOOSER. Otherwise -> SHOOTER (sudden death once past ROUNDS).
  - Decision uses the already-updated counters.
- WINNER/LOOSER:
  - Counters frozen.
  - start=1 -> START (counters retained until the next game begins).
- Latency:
  - shot_done -> score/is_scored updated: 1 cycle.
  - shot_done -> state change: exactly HOLD_CYCLES+1 cycles.
- Boundaries:
  - shot_done outside SHOOTER/KEEPER is ignored.
  - start during SHOOTER/KEEPER is ignored.
  - start and shot_done in the same cycle in START: start wins.
  - shot_goal is don't-care when shot_done=0.
  - If rst asserts mid-hold, everything returns to reset values immediately.
- Illegal state encodings recover to START.

Optional Feature:
- Macro: GAME_EARLY_FINISH_EN.
- Defined: at turn resolution during regulation (round_counter<ROUNDS, or this resolution completes a round <=ROUNDS), compute remaining shots per side:
  - player_left = ROUNDS - player_shots_taken; opponent_left likewise.
  - If player > opponent+opponent_left -> WINNER.
  - If opponent > player+player_left -> LOOSER.
  - This check runs after SHOOTER turns as well as KEEPER turns.
- Undefined: decisions only after complete rounds as above. Port list is identical in both builds.

Decomposition:
- game_pkg holds:
  - g_state enum (START, KEEPER, SHOOTER, WINNER, LOOSER) and g_mode enum (SOLO, MULTI).
  - Constants SCORE_W=4 and ROUND_W=4.
  - Default HOLD_CYCLES value.
- One natural sub-module: result_hold_timer (load/decrement/expire pulse, width $clog2(HOLD_CYCLES)). FSM and counters stay in game_controller.

Test Plan (ROUNDS=5, HOLD_CYCLES=4):
- Reset then start with mode_sel=0 -> state SHOOTER, game_mode=SOLO, score=0x00, round_counter=0, all on the cycle after start.
- In SHOOTER, shot_done with shot_goal=1 -> next cycle score=0x10, is_scored=1, hold_active=1; state KEEPER exactly 5 cycles after shot_done; extra shot_done during hold leaves score=0x10.
- 5 rounds with the player scoring 3 and the opponent 2 (early finish undefined) -> after the 5th KEEPER hold: WINNER, score=0x32, round_counter=5. Then start -> START with score still 0x32; start again -> score=0x00.
- Tied 5-5 after 5 rounds -> SHOOTER (sudden death). Round 6: player misses, opponent scores -> LOOSER, score=0x56, round_counter=6.
- Assert rst mid-hold (timer=2) -> same instant: state START, hold_active=0, score=0.
- With GAME_EARLY_FINISH_EN defined: player 3/3, opponent 0/3 -> after the opponent's 3rd miss resolves: WINNER with round_counter=3.
